// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK polling controller.
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_SETTLE,
    ST_CAPTURE,
    ST_GAP
  } jstk_state_e;

  // Command byte header; the two LED bits follow it.
  localparam logic [5:0] JSTK_CMD_HDR = 6'b100000;

  // Field positions inside the 40-bit DOUT frame.
  localparam int X_LO_MSB = 39;
  localparam int X_LO_LSB = 32;
  localparam int X_HI_MSB = 25;
  localparam int X_HI_LSB = 24;
  localparam int Y_LO_MSB = 23;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_MSB = 9;
  localparam int Y_HI_LSB = 8;
  localparam int BTN_MSB  = 2;
  localparam int BTN_LSB  = 0;

  // Guard interval keeping sndRec low long enough for spiCtrl to re-arm.
  localparam int GAP_CYCLES = 16;
  localparam int TMR_W      = 17;

  function automatic logic [9:0] jstk_x(input logic [39:0] d);
    return {d[X_HI_MSB:X_HI_LSB], d[X_LO_MSB:X_LO_LSB]};
  endfunction

  function automatic logic [9:0] jstk_y(input logic [39:0] d);
    return {d[Y_HI_MSB:Y_HI_LSB], d[Y_LO_MSB:Y_LO_LSB]};
  endfunction

endpackage

// File: rtl/jstk_poll_ctrl_if.sv
// User/PmodJSTK-facing signal bundle of the polling controller.
// slave = the controller, master = its environment (user logic + PmodJSTK).
interface jstk_poll_ctrl_if;
  logic        enable;
  logic        force_poll;
  logic [1:0]  led;
  logic        jstk_sndRec;
  logic [39:0] jstk_DIN;
  logic        jstk_SS;
  logic [39:0] jstk_DOUT;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [2:0]  btn;
  logic        sample_valid;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  enable, force_poll, led, jstk_SS, jstk_DOUT,
    output jstk_sndRec, jstk_DIN, x_pos, y_pos, btn,
           sample_valid, busy, timeout_err
  );

  modport master (
    output enable, force_poll, led, jstk_SS, jstk_DOUT,
    input  jstk_sndRec, jstk_DIN, x_pos, y_pos, btn,
           sample_valid, busy, timeout_err
  );
endinterface

// File: rtl/jstk_sync2.sv
// Two-flop synchronizer for the slow-domain SS line.
module jstk_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  // Shift the async input through two stages; reset to the idle level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/jstk_poll_ctrl.sv
// Periodic / on-demand poll scheduler for the PmodJSTK SPI master.
// Issues sndRec, tracks the transfer via synchronized SS, unpacks DOUT.
module jstk_poll_ctrl
  import jstk_pkg::*;
#(
  parameter int POLL_CYCLES   = 1_000_000,
  parameter int START_TIMEOUT = 4096,
  parameter int DONE_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 4
) (
  input logic            CLK,
  input logic            RST,
  jstk_poll_ctrl_if.slave bus
);
  localparam int PC_W = $clog2(POLL_CYCLES);

  jstk_state_e       r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [PC_W-1:0]   r_poll_cnt;
  logic              r_poll_pend;
  logic              r_sndrec;
  logic [1:0]        r_led_q;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [2:0]        r_btn;
  logic              r_valid;
  logic              r_busy;
  logic              r_tmo;

  logic              w_ss_s;
  logic              w_wrap;
  logic              w_req_entry;
  logic              w_unused_dout;

  jstk_sync2 #(.RST_VAL(1'b1)) u_ss_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (bus.jstk_SS),
    .o_q   (w_ss_s)
  );

  assign w_wrap      = bus.enable && (r_poll_cnt == PC_W'(POLL_CYCLES - 1));
  assign w_req_entry = (r_state == ST_IDLE) && r_poll_pend;

  // Free-running poll interval counter, parked at zero while disabled.
  always_ff @(posedge CLK) begin
    if (RST || !bus.enable || w_wrap) r_poll_cnt <= '0;
    else                              r_poll_cnt <= r_poll_cnt + 1'b1;
  end

  // Pending-poll flag: requests arriving while busy merge into one; a new
  // request in the same cycle as REQ entry is kept rather than lost.
  always_ff @(posedge CLK) begin
    if (RST) r_poll_pend <= 1'b0;
    else     r_poll_pend <= (r_poll_pend && !w_req_entry) || bus.force_poll || w_wrap;
  end

  // Transfer sequencer; all outputs registered, timer restarts on every entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_sndrec <= 1'b0;
      r_led_q  <= 2'b00;
      r_x      <= '0;
      r_y      <= '0;
      r_btn    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_timer <= r_timer + 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (r_poll_pend) begin
            r_state  <= ST_REQ;
            r_sndrec <= 1'b1;
            r_led_q  <= bus.led;
            r_busy   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!w_ss_s) begin
            r_state  <= ST_XFER;
            r_timer  <= '0;
            r_sndrec <= 1'b0;
          end else if (r_timer == TMR_W'(START_TIMEOUT - 1)) begin
            r_state  <= ST_GAP;
            r_timer  <= '0;
            r_sndrec <= 1'b0;
            r_tmo    <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_ss_s) begin
            r_state <= ST_SETTLE;
            r_timer <= '0;
          end else if (r_timer == TMR_W'(DONE_TIMEOUT - 1)) begin
            r_state <= ST_GAP;
            r_timer <= '0;
            r_tmo   <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_timer == TMR_W'(SETTLE_CYCLES - 1)) begin
            r_state <= ST_CAPTURE;
            r_timer <= '0;
          end
        end
        ST_CAPTURE: begin
          r_x     <= jstk_x(bus.jstk_DOUT);
          r_y     <= jstk_y(bus.jstk_DOUT);
          r_btn   <= bus.jstk_DOUT[BTN_MSB:BTN_LSB];
          r_valid <= 1'b1;
          r_tmo   <= 1'b0;
          r_state <= ST_GAP;
          r_timer <= '0;
        end
        ST_GAP: begin
          if (r_timer == TMR_W'(GAP_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_timer  <= '0;
          r_sndrec <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  // DOUT bits outside the decoded fields carry no information we use.
  assign w_unused_dout = ^{bus.jstk_DOUT[31:26], bus.jstk_DOUT[15:10], bus.jstk_DOUT[7:3]};

  assign bus.jstk_sndRec  = r_sndrec;
  assign bus.jstk_DIN     = {JSTK_CMD_HDR, r_led_q, 32'h0};
  assign bus.x_pos        = r_x;
  assign bus.y_pos        = r_y;
  assign bus.btn          = r_btn;
  assign bus.sample_valid = r_valid;
  assign bus.busy         = r_busy;
  assign bus.timeout_err  = r_tmo;
endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// Bench for jstk_poll_ctrl: PmodJSTK behavioural model, directed stimulus,
// scoreboard of expected samples checked by a monitor thread.
module tb_jstk_poll_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  jstk_poll_ctrl_if bus();

  jstk_poll_ctrl #(.POLL_CYCLES(1000)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] b;
  } samp_t;

  samp_t       exp_q[$];
  logic [39:0] dout_q[$];
  int          pulse_cyc[$];
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          n_pulse = 0;
  int          cyc     = 0;

  logic        m_ss     = 1'b1;
  logic        idle_low = 1'b0;
  logic [39:0] m_dout   = '0;
  logic        m_hang   = 1'b0;
  int          m_delay  = 300;
  int          m_len    = 200;

  assign bus.jstk_SS   = m_ss && !idle_low;
  assign bus.jstk_DOUT = m_dout;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.jstk_sndRec;
      1:       return bus.jstk_SS;
      2:       return bus.sample_valid;
      default: return bus.busy;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int sel, input logic val, input int maxc);
    int k = 0;
    while (sig(sel) !== val && k < maxc) begin
      @(negedge CLK);
      k++;
    end
    if (sig(sel) !== val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait timed out after %0d cycles, required level %0b", nm, maxc, val);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input logic [39:0] d, input logic [9:0] x, input logic [9:0] y,
                      input logic [2:0] b);
    samp_t s;
    s.x = x; s.y = y; s.b = b;
    dout_q.push_back(d);
    exp_q.push_back(s);
  endtask

  task automatic pulse_force();
    bus.force_poll = 1'b1;
    @(negedge CLK);
    bus.force_poll = 1'b0;
  endtask

  // PmodJSTK stand-in: answers sndRec by pulling SS low, then returns DOUT.
  task automatic model();
    logic [39:0] d;
    forever begin
      @(posedge CLK); #2;
      if (bus.jstk_sndRec) begin
        if (m_hang) begin
          while (bus.jstk_sndRec) begin @(posedge CLK); #2; end
        end else begin
          d = 40'h0;
          if (dout_q.size() > 0) d = dout_q.pop_front();
          repeat (m_delay) @(posedge CLK);
          #2 m_ss = 1'b0;
          repeat (m_len) @(posedge CLK);
          #2;
          m_dout = d;
          m_ss   = 1'b1;
          while (bus.jstk_sndRec) begin @(posedge CLK); #2; end
        end
      end
    end
  endtask

  task automatic monitor();
    samp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && bus.sample_valid) begin
        n_pulse++;
        pulse_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sv_unexpected: got sample x=%0h y=%0h required none", bus.x_pos, bus.y_pos);
        end else begin
          e = exp_q.pop_front();
          chk("x_pos", bus.x_pos, e.x);
          chk("y_pos", bus.y_pos, e.y);
          chk("btn", bus.btn, e.b);
          chk("tmo_on_capture", bus.timeout_err, 0);
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sndrec"}, bus.jstk_sndRec, 0);
    chk({tag, "_din"}, bus.jstk_DIN, 40'h80_0000_0000);
    chk({tag, "_x"}, bus.x_pos, 0);
    chk({tag, "_y"}, bus.y_pos, 0);
    chk({tag, "_btn"}, bus.btn, 0);
    chk({tag, "_sv"}, bus.sample_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_tmo"}, bus.timeout_err, 0);
  endtask

  task automatic run_tests();
    int k;
    int p0;
    logic [39:0] din;

    bus.enable = 1'b0; bus.force_poll = 1'b0; bus.led = 2'b00;
    RST = 1'b1;
    clk_n(3);
    check_reset_vals("rst");
    RST = 1'b0;
    clk_n(2);

    // Forced poll: sndRec latency, SS-fall to XFER latency, capture latency.
    push(40'hA5_01_3C_02_05, 10'h1A5, 10'h23C, 3'b101);
    bus.force_poll = 1'b1;
    @(negedge CLK);
    bus.force_poll = 1'b0;
    chk("sndrec_n1", bus.jstk_sndRec, 0);
    @(negedge CLK);
    chk("sndrec_n2", bus.jstk_sndRec, 1);
    chk("busy_req", bus.busy, 1);
    wait_for("ss_fall", 1, 1'b0, 400);
    clk_n(1); chk("sndrec_ss1", bus.jstk_sndRec, 1);
    clk_n(1); chk("sndrec_ss2", bus.jstk_sndRec, 1);
    clk_n(1); chk("sndrec_drop", bus.jstk_sndRec, 0);
    wait_for("ss_rise", 1, 1'b1, 300);
    clk_n(7); chk("sv_early", bus.sample_valid, 0);
    clk_n(1); chk("sv_latency", bus.sample_valid, 1);
    clk_n(1); chk("sv_one_cycle", bus.sample_valid, 0);
    wait_for("idle1", 3, 1'b0, 40);

    // SS low while idle must not start anything.
    idle_low = 1'b1;
    clk_n(20);
    chk("idle_ss_busy", bus.busy, 0);
    chk("idle_ss_sndrec", bus.jstk_sndRec, 0);
    idle_low = 1'b0;
    clk_n(4);

    // LED bits frozen for the whole transfer.
    m_delay = 20; m_len = 150;
    bus.led = 2'b10;
    push(40'hFF_03_FF_03_07, 10'h3FF, 10'h3FF, 3'b111);
    pulse_force();
    wait_for("led_req", 0, 1'b1, 5);
    din = bus.jstk_DIN; chk("din_req", din[39:32], 8'h82);
    bus.led = 2'b01;
    wait_for("led_ss", 1, 1'b0, 100);
    din = bus.jstk_DIN; chk("din_xfer", din[39:32], 8'h82);
    wait_for("led_sv", 2, 1'b1, 300);
    din = bus.jstk_DIN; chk("din_gap", din[39:32], 8'h82);
    chk("din_low", din[31:0], 0);
    wait_for("idle2", 3, 1'b0, 40);

    // SS never falls: REQ gives up after START_TIMEOUT cycles.
    m_hang = 1'b1;
    pulse_force();
    wait_for("tmo_req", 0, 1'b1, 5);
    k = 0;
    while (bus.jstk_sndRec && k < 5000) begin @(negedge CLK); k++; end
    chk("req_timeout_len", k, 4096);
    chk("tmo_set", bus.timeout_err, 1);
    chk("busy_gap", bus.busy, 1);
    wait_for("idle3", 3, 1'b0, 40);
    chk("tmo_sticky", bus.timeout_err, 1);
    m_hang = 1'b0;
    push(40'h00_00_00_00_00, 10'h000, 10'h000, 3'b000);
    pulse_force();
    wait_for("tmo_recover", 2, 1'b1, 400);
    chk("tmo_cleared", bus.timeout_err, 0);
    wait_for("idle4", 3, 1'b0, 40);

    // Automatic polling at POLL_CYCLES, enable dropped mid-transfer.
    push(40'h12_FE_34_FD_F8, 10'h212, 10'h134, 3'b000);
    push(40'hA5_01_3C_02_05, 10'h1A5, 10'h23C, 3'b101);
    push(40'hFF_03_FF_03_07, 10'h3FF, 10'h3FF, 3'b111);
    p0 = pulse_cyc.size();
    bus.enable = 1'b1;
    k = 0;
    while (n_pulse < p0 + 2 && k < 2500) begin @(negedge CLK); k++; end
    wait_for("poll3_req", 0, 1'b1, 1100);
    bus.enable = 1'b0;
    k = 0;
    while (n_pulse < p0 + 3 && k < 1100) begin @(negedge CLK); k++; end
    if (pulse_cyc.size() >= p0 + 3) begin
      chk("period_1", pulse_cyc[p0+1] - pulse_cyc[p0], 1000);
      chk("period_2", pulse_cyc[p0+2] - pulse_cyc[p0+1], 1000);
    end else begin
      chk("periodic_pulses", pulse_cyc.size() - p0, 3);
    end
    wait_for("idle5", 3, 1'b0, 40);

    // force coinciding with poll-counter wrap yields one poll.
    push(40'h5A_02_C3_01_02, 10'h25A, 10'h1C3, 3'b010);
    p0 = n_pulse;
    bus.enable = 1'b1;
    clk_n(999);
    bus.force_poll = 1'b1;
    clk_n(1);
    bus.force_poll = 1'b0;
    bus.enable = 1'b0;
    clk_n(1500);
    chk("single_poll", n_pulse - p0, 1);

    // Reset in the middle of XFER.
    dout_q.push_back(40'hFF_FF_FF_FF_FF);
    pulse_force();
    wait_for("rst_ss", 1, 1'b0, 100);
    clk_n(5);
    chk("busy_xfer", bus.busy, 1);
    RST = 1'b1;
    clk_n(1);
    check_reset_vals("midrst");
    RST = 1'b0;
    wait_for("rst_ss_rise", 1, 1'b1, 200);
    clk_n(20);
    chk("post_rst_idle", bus.busy, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    fork
      model();
      monitor();
      begin
        run_tests();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    join_any
  end
endmodule
